// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown/up timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [6:0] SEG_BLANK    = 7'h7F;

    // Four BCD digits of an mm:ss value
    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } mmss_t;

    // Saturate a single digit to an upper limit
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low seven-segment pattern (bit 6 = g ... bit 0 = a).
module seg7_decoder
    import timer_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_c
);

    // Pure lookup; unknown codes blank the digit
    always_comb begin
        seg_c = SEG_BLANK;
        case (value)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss up/down timer with start/pause/load control and seven-segment outputs.
// Define COUNTDOWN_TIMER_HEX_EN to build the HEX decoders; otherwise HEX3..HEX0 are blank.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MIN_MAX  = 99
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       dir,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    MIN_MAX_V  = 7'(MIN_MAX);
    localparam logic [3:0]    MIN_MAX_T  = 4'(MIN_MAX / 10);
    localparam logic [3:0]    MIN_MAX_O  = 4'(MIN_MAX % 10);

    timer_state_t  state_q, state_d;
    mmss_t         count_q, count_d;
    mmss_t         target_q, target_d;
    logic          dir_q, dir_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          done_q, done_d;

    mmss_t         load_clamped;
    logic [6:0]    load_min_val;
    mmss_t         count_tick;
    logic          tick;
    logic          term_now;
    logic          term_tick;

    // Saturate loaded digits to a legal mm:ss value
    always_comb begin
        load_clamped.min_t = clamp_digit(load_min[7:4], BCD_MAX);
        load_clamped.min_o = clamp_digit(load_min[3:0], BCD_MAX);
        load_clamped.sec_t = clamp_digit(load_sec[7:4], SEC_TENS_MAX);
        load_clamped.sec_o = clamp_digit(load_sec[3:0], BCD_MAX);
        load_min_val = 7'(load_clamped.min_t) * 7'd10 + 7'(load_clamped.min_o);
        if (load_min_val > MIN_MAX_V) begin
            load_clamped.min_t = MIN_MAX_T;
            load_clamped.min_o = MIN_MAX_O;
        end
    end

    // One-second BCD step in the current direction, plus terminal detection
    always_comb begin
        count_tick = count_q;
        if (!dir_q) begin
            if (count_q.sec_o != 4'd0) begin
                count_tick.sec_o = count_q.sec_o - 4'd1;
            end else if (count_q.sec_t != 4'd0) begin
                count_tick.sec_t = count_q.sec_t - 4'd1;
                count_tick.sec_o = BCD_MAX;
            end else begin
                count_tick.sec_t = SEC_TENS_MAX;
                count_tick.sec_o = BCD_MAX;
                if (count_q.min_o != 4'd0) begin
                    count_tick.min_o = count_q.min_o - 4'd1;
                end else begin
                    count_tick.min_o = BCD_MAX;
                    count_tick.min_t = count_q.min_t - 4'd1;
                end
            end
        end else begin
            if (count_q.sec_o != BCD_MAX) begin
                count_tick.sec_o = count_q.sec_o + 4'd1;
            end else begin
                count_tick.sec_o = 4'd0;
                if (count_q.sec_t != SEC_TENS_MAX) begin
                    count_tick.sec_t = count_q.sec_t + 4'd1;
                end else begin
                    count_tick.sec_t = 4'd0;
                    if (count_q.min_o != BCD_MAX) begin
                        count_tick.min_o = count_q.min_o + 4'd1;
                    end else begin
                        count_tick.min_o = 4'd0;
                        count_tick.min_t = count_q.min_t + 4'd1;
                    end
                end
            end
        end
        term_now  = dir_q ? (count_q == target_q)    : (count_q == '0);
        term_tick = dir_q ? (count_tick == target_q) : (count_tick == '0);
        tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        dir_d    = dir_q;
        presc_d  = presc_q;

        if (load) begin
            state_d = ST_IDLE;
            presc_d = '0;
            dir_d   = dir;
            if (!dir) begin
                count_d = load_clamped;
            end else begin
                count_d  = '0;
                target_d = load_clamped;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (start) begin
                        state_d = term_now ? ST_EXPIRED : ST_RUN;
                        // Resume keeps the partial second accumulated before the pause
                        if (state_q == ST_IDLE) begin
                            presc_d = '0;
                        end
                    end
                end
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        count_d = count_tick;
                    end
                    if (tick && term_tick) begin
                        state_d = ST_EXPIRED;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
        done_d    = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            target_q  <= '0;
            dir_q     <= 1'b0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            expired_q <= expired_d;
            done_q    <= done_d;
        end
    end

    assign min_bcd = {count_q.min_t, count_q.min_o};
    assign sec_bcd = {count_q.sec_t, count_q.sec_o};
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

`ifdef COUNTDOWN_TIMER_HEX_EN
    seg7_decoder u_hex3 (.value(count_q.min_t), .seg_c(HEX3));
    seg7_decoder u_hex2 (.value(count_q.min_o), .seg_c(HEX2));
    seg7_decoder u_hex1 (.value(count_q.sec_t), .seg_c(HEX1));
    seg7_decoder u_hex0 (.value(count_q.sec_o), .seg_c(HEX0));
`else
    assign HEX3 = SEG_BLANK;
    assign HEX2 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
    assign HEX0 = SEG_BLANK;
`endif

endmodule
